slave_port_v3: RTL and testbench

//  Bit-serial system-bus slave port with burst support; next generation of the v2 port.

---
 rtl/slave_port_v3_pkg.sv | 23 ++
 rtl/slave_port_v3_shift_reg.sv | 29 ++
 rtl/slave_port_v3.sv | 215 +++++++++++++++++++++
 tb/tb_slave_port_v3.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/slave_port_v3_pkg.sv
// Shared types and helpers for the bit-serial bus slave port (v3).
// State encoding is fixed so that debug tooling can decode dbg_state.
package slave_port_pkg;

   typedef enum logic [2:0] {
      SP_IDLE  = 3'd0,
      SP_HDR   = 3'd1,
      SP_WDATA = 3'd2,
      SP_WRITE = 3'd3,
      SP_RWAIT = 3'd4,
      SP_SEND  = 3'd5
   } sp_state_t;

   localparam int SP_STATE_W = 3;

   // Width of a counter that must hold the value n (never narrower than 1 bit).
   function automatic int sp_cnt_w(input int n);
      int w;
      w = $clog2(n + 1);
      return (w < 1) ? 1 : w;
   endfunction

endpackage

// File: rtl/slave_port_v3_shift_reg.sv
// MSB-first shifter with synchronous clear, parallel load and serial input.
// Load takes priority over shift when both are requested.
module sp_shift_reg #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             i_load,
   input  logic [WIDTH-1:0] i_load_data,
   input  logic             i_shift,
   input  logic             i_serial,
   output logic [WIDTH-1:0] o_data
);

   logic [WIDTH-1:0] r_data;

   always_ff @(posedge clk) begin
      if (!rstn) begin
         r_data <= '0;
      end else if (i_load) begin
         r_data <= i_load_data;
      end else if (i_shift) begin
         r_data <= {r_data[WIDTH-2:0], i_serial};
      end
   end

   assign o_data = r_data;

endmodule

// File: rtl/slave_port_v3.sv
// Bit-serial bus slave port: serial header (address + burst length), then a
// burst of MSB-first data words written to or read from a synchronous RAM.
module slave_port_v3
   import slave_port_pkg::*;
#(
   parameter int ADDR_WIDTH   = 16,
   parameter int DATA_WIDTH   = 8,
   parameter int LEN_WIDTH    = 4,
   parameter int READ_LATENCY = 4,
   parameter bit SPLIT_EN     = 1'b0
) (
   input  logic                  clk,
   input  logic                  rstn,
   input  logic                  master_valid,
   input  logic                  master_ready,
   input  logic                  mode,
   input  logic                  wr_bus,
   output logic                  rd_bus,
   output logic                  slave_ready,
   output logic                  slave_valid,
   output logic                  split,
   input  logic [DATA_WIDTH-1:0] ram_in,
   output logic [DATA_WIDTH-1:0] ram_out,
   output logic [ADDR_WIDTH-1:0] ram_addr_out,
   output logic                  ram_wr_en,
   output sp_state_t             dbg_state
);

   // Handshake: a wr_bus bit is consumed on a rising edge where slave_ready
   // and master_valid are both 1; an rd_bus bit is consumed on a rising edge
   // where slave_valid and master_ready are both 1. All outputs are Moore.

   localparam int HDR_W   = ADDR_WIDTH + LEN_WIDTH;
   localparam int BIT_MAX = (HDR_W > DATA_WIDTH) ? HDR_W : DATA_WIDTH;
   localparam int BIT_W   = sp_cnt_w(BIT_MAX);
   localparam int LAT_W   = sp_cnt_w(READ_LATENCY);

   localparam logic [BIT_W-1:0] HDR_LAST  = BIT_W'(HDR_W - 1);
   localparam logic [BIT_W-1:0] DATA_LAST = BIT_W'(DATA_WIDTH - 1);
   localparam logic [LAT_W-1:0] LAT_LAST  = LAT_W'(READ_LATENCY - 1);

   sp_state_t            r_state;
   sp_state_t            w_next;
   logic [BIT_W-1:0]     r_bit_cnt;
   logic [LAT_W-1:0]     r_lat_cnt;
   logic [LEN_WIDTH-1:0] r_idx;
   logic                 r_mode;

   logic [HDR_W-1:0]      w_hdr;
   logic [DATA_WIDTH-1:0] w_data;
   logic [ADDR_WIDTH-1:0] w_base;
   logic [LEN_WIDTH-1:0]  w_len;
   logic [ADDR_WIDTH-1:0] w_addr;
   logic                  w_last;
   logic                  w_mode_eff;
   logic                  w_dat_serial;

   logic w_slave_ready;
   logic w_slave_valid;
   logic w_split;
   logic w_wr_en;
   logic w_hdr_shift;
   logic w_dat_shift;
   logic w_dat_load;
   logic w_idx_inc;

   assign w_base = w_hdr[HDR_W-1 -: ADDR_WIDTH];
   assign w_len  = w_hdr[LEN_WIDTH-1:0];
   // Address wraps naturally modulo 2^ADDR_WIDTH.
   assign w_addr = w_base + ADDR_WIDTH'(r_idx);
   assign w_last = (r_idx == w_len);

   // The first header bit decides the direction even before r_mode updates.
   assign w_mode_eff   = (r_bit_cnt == '0) ? mode : r_mode;
   assign w_dat_serial = (r_state == SP_WDATA) ? wr_bus : 1'b0;

   sp_shift_reg #(.WIDTH(HDR_W)) u_hdr_sr (
      .clk         (clk),
      .rstn        (rstn),
      .i_load      (1'b0),
      .i_load_data ({HDR_W{1'b0}}),
      .i_shift     (w_hdr_shift),
      .i_serial    (wr_bus),
      .o_data      (w_hdr)
   );

   // One data shifter serves both directions: a transaction is either a write or a read.
   sp_shift_reg #(.WIDTH(DATA_WIDTH)) u_dat_sr (
      .clk         (clk),
      .rstn        (rstn),
      .i_load      (w_dat_load),
      .i_load_data (ram_in),
      .i_shift     (w_dat_shift),
      .i_serial    (w_dat_serial),
      .o_data      (w_data)
   );

   always_ff @(posedge clk) begin
      if (!rstn) begin
         r_state <= SP_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next        = r_state;
      w_slave_ready = 1'b0;
      w_slave_valid = 1'b0;
      w_split       = 1'b0;
      w_wr_en       = 1'b0;
      w_hdr_shift   = 1'b0;
      w_dat_shift   = 1'b0;
      w_dat_load    = 1'b0;
      w_idx_inc     = 1'b0;
      unique case (r_state)
         SP_IDLE: begin
            if (master_valid) w_next = SP_HDR;
         end
         SP_HDR: begin
            w_slave_ready = 1'b1;
            if (!master_valid) begin
               w_next = SP_IDLE;
            end else begin
               w_hdr_shift = 1'b1;
               if (r_bit_cnt == HDR_LAST) w_next = w_mode_eff ? SP_WDATA : SP_RWAIT;
            end
         end
         SP_WDATA: begin
            w_slave_ready = 1'b1;
            if (!master_valid) begin
               w_next = SP_IDLE;
            end else begin
               w_dat_shift = 1'b1;
               if (r_bit_cnt == DATA_LAST) w_next = SP_WRITE;
            end
         end
         SP_WRITE: begin
            w_wr_en = 1'b1;
            if (w_last) begin
               w_next = SP_IDLE;
            end else begin
               w_idx_inc = 1'b1;
               w_next    = SP_WDATA;
            end
         end
         SP_RWAIT: begin
            w_split = SPLIT_EN;
            if (r_lat_cnt == LAT_LAST) begin
               w_dat_load = 1'b1;
               w_next     = SP_SEND;
            end
         end
         SP_SEND: begin
            w_slave_valid = 1'b1;
            if (master_ready) begin
               w_dat_shift = 1'b1;
               if (r_bit_cnt == DATA_LAST) begin
                  if (w_last) begin
                     w_next = SP_IDLE;
                  end else begin
                     w_idx_inc = 1'b1;
                     w_next    = SP_RWAIT;
                  end
               end
            end
         end
         default: begin
            w_next = SP_IDLE;
         end
      endcase
   end

   // Bit counter restarts on every state change, so each phase counts from zero.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         r_bit_cnt <= '0;
         r_lat_cnt <= '0;
         r_idx     <= '0;
         r_mode    <= 1'b0;
      end else begin
         if (w_next != r_state) begin
            r_bit_cnt <= '0;
         end else if (w_hdr_shift || w_dat_shift) begin
            r_bit_cnt <= r_bit_cnt + BIT_W'(1);
         end

         if (r_state == SP_RWAIT && w_next == SP_RWAIT) begin
            r_lat_cnt <= r_lat_cnt + LAT_W'(1);
         end else begin
            r_lat_cnt <= '0;
         end

         if (r_state == SP_IDLE || r_state == SP_HDR) begin
            r_idx <= '0;
         end else if (w_idx_inc) begin
            r_idx <= r_idx + LEN_WIDTH'(1);
         end

         if (r_state == SP_HDR && master_valid && r_bit_cnt == '0) begin
            r_mode <= mode;
         end
      end
   end

   assign rd_bus       = w_slave_valid & w_data[DATA_WIDTH-1];
   assign slave_ready  = w_slave_ready;
   assign slave_valid  = w_slave_valid;
   assign split        = w_split;
   assign ram_wr_en    = w_wr_en;
   assign ram_out      = w_data;
   assign ram_addr_out = w_addr;
   assign dbg_state    = r_state;

endmodule

// File: tb/tb_slave_port_v3.sv
// Randomized bench for slave_port_v3: a driver issues serial transactions, a
// reference memory predicts RAM writes and read words, a negedge monitor checks.
module tb_slave_port_v3;
   import slave_port_pkg::*;

   localparam int AW = 16;
   localparam int DW = 8;
   localparam int LW = 4;
   localparam int RL = 4;

   logic clk = 1'b0;
   logic rstn = 1'b0;
   logic master_valid = 1'b0;
   logic master_ready = 1'b0;
   logic mode = 1'b0;
   logic wr_bus = 1'b0;

   logic          rd_bus0, slave_ready0, slave_valid0, split0, ram_wr_en0;
   logic [DW-1:0] ram_in0, ram_out0;
   logic [AW-1:0] addr0;
   sp_state_t     st0;
   logic          rd_bus1, slave_ready1, slave_valid1, split1, ram_wr_en1;
   logic [DW-1:0] ram_in1, ram_out1;
   logic [AW-1:0] addr1;
   sp_state_t     st1;

   logic [DW-1:0] ram_mem [65536];
   logic [DW-1:0] ref_mem [65536];
   logic [DW-1:0] wbuf [16];

   logic [AW+DW-1:0] exp_wr_q[$];
   logic [DW-1:0]    exp_rd_q[$];

   int checks = 0;
   int failures = 0;

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   // ---------------- DUTs: split disabled and split enabled ----------------
   slave_port_v3 #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LEN_WIDTH(LW),
                   .READ_LATENCY(RL), .SPLIT_EN(1'b0)) dut0 (
      .clk(clk), .rstn(rstn), .master_valid(master_valid), .master_ready(master_ready),
      .mode(mode), .wr_bus(wr_bus), .rd_bus(rd_bus0), .slave_ready(slave_ready0),
      .slave_valid(slave_valid0), .split(split0), .ram_in(ram_in0), .ram_out(ram_out0),
      .ram_addr_out(addr0), .ram_wr_en(ram_wr_en0), .dbg_state(st0));

   slave_port_v3 #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LEN_WIDTH(LW),
                   .READ_LATENCY(RL), .SPLIT_EN(1'b1)) dut1 (
      .clk(clk), .rstn(rstn), .master_valid(master_valid), .master_ready(master_ready),
      .mode(mode), .wr_bus(wr_bus), .rd_bus(rd_bus1), .slave_ready(slave_ready1),
      .slave_valid(slave_valid1), .split(split1), .ram_in(ram_in1), .ram_out(ram_out1),
      .ram_addr_out(addr1), .ram_wr_en(ram_wr_en1), .dbg_state(st1));

   // RAM behind the port; dut1 mirrors dut0's writes so only dut0 writes here.
   assign ram_in0 = ram_mem[addr0];
   assign ram_in1 = ram_mem[addr1];
   always @(posedge clk) begin
      if (rstn && ram_wr_en0) ram_mem[addr0] <= ram_out0;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- monitor / scoreboard ----------------
   logic [DW-1:0]    rx_word = '0;
   logic [AW+DW-1:0] wr_exp;
   logic [DW-1:0]    rd_exp;
   int  rx_bits = 0;
   int  gap = 0;
   int  split_run0 = 0;
   int  split_run1 = 0;
   logic prev_valid = 1'b0;

   always @(negedge clk) begin
      if (!rstn) begin
         rx_bits = 0; gap = 0; split_run0 = 0; split_run1 = 0; prev_valid = 1'b0;
      end else begin
         if (ram_wr_en0) begin
            check("ready_low_in_write", {31'b0, slave_ready0}, 32'd0);
            if (exp_wr_q.size() == 0) begin
               check("unexpected_write", {16'b0, addr0}, 32'hFFFF_FFFF);
            end else begin
               wr_exp = exp_wr_q.pop_front();
               check("wr_addr", {16'b0, addr0}, {16'b0, wr_exp[AW+DW-1:DW]});
               check("wr_data", {24'b0, ram_out0}, {24'b0, wr_exp[DW-1:0]});
            end
         end
         if (slave_valid0 && !prev_valid) begin
            check("read_latency", gap, RL);
            check("split_cycles_en", split_run1, RL);
            check("split_cycles_dis", split_run0, 0);
         end
         if (slave_valid0) check("split_in_send", {31'b0, split1}, 32'd0);
         if (slave_valid0 && master_ready) begin
            rx_word = {rx_word[DW-2:0], rd_bus0};
            rx_bits++;
            if (rx_bits == DW) begin
               rx_bits = 0;
               if (exp_rd_q.size() == 0) begin
                  check("unexpected_read", {24'b0, rx_word}, 32'hFFFF_FFFF);
               end else begin
                  rd_exp = exp_rd_q.pop_front();
                  check("rd_word", {24'b0, rx_word}, {24'b0, rd_exp});
               end
            end
         end
         if (slave_ready0 || slave_valid0) begin
            gap = 0; split_run0 = 0; split_run1 = 0;
         end else begin
            gap++;
            if (split0) split_run0++;
            if (split1) split_run1++;
         end
         prev_valid = slave_valid0;
      end
   end

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_bit(input logic b);
      int n = 0;
      while (!slave_ready0 && n < 50) begin
         tick();
         n++;
      end
      if (!slave_ready0) check("ready_timeout", {31'b0, slave_ready0}, 32'd1);
      wr_bus = b;
      tick();
   endtask

   task automatic do_header(input logic [AW-1:0] a, input logic [LW-1:0] l, input logic m);
      logic [AW+LW-1:0] h;
      h = {a, l};
      mode = m;
      master_valid = 1'b1;
      tick();
      for (int i = AW + LW - 1; i >= 0; i--) send_bit(h[i]);
   endtask

   // Writes wbuf[0..l] starting at a; reference memory updated at issue time.
   task automatic do_write(input logic [AW-1:0] a, input logic [LW-1:0] l);
      logic [AW-1:0] wa;
      for (int i = 0; i <= int'(l); i++) begin
         wa = a + AW'(i);
         exp_wr_q.push_back({wa, wbuf[i]});
         ref_mem[wa] = wbuf[i];
      end
      do_header(a, l, 1'b1);
      for (int i = 0; i <= int'(l); i++) begin
         for (int b = DW - 1; b >= 0; b--) send_bit(wbuf[i][b]);
      end
      master_valid = 1'b0;
      wr_bus = 1'b0;
      tick();
      tick();
   endtask

   task automatic do_read(input logic [AW-1:0] a, input logic [LW-1:0] l, input bit toggle);
      int total;
      int got = 0;
      int n = 0;
      for (int i = 0; i <= int'(l); i++) exp_rd_q.push_back(ref_mem[a + AW'(i)]);
      do_header(a, l, 1'b0);
      master_valid = 1'b0;
      wr_bus = 1'b0;
      total = (int'(l) + 1) * DW;
      while (got < total && n < 3000) begin
         master_ready = toggle ? ~master_ready : 1'($urandom_range(0, 1));
         if (slave_valid0 && master_ready) got++;
         tick();
         n++;
      end
      if (got < total) check("read_timeout", got, total);
      master_ready = 1'b0;
      tick();
   endtask

   task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
      ram_mem[a] = d;
      ref_mem[a] = d;
   endtask

   task automatic check_quiet(input string tag);
      check({tag, "_state0"}, {29'b0, st0}, {29'b0, SP_IDLE});
      check({tag, "_state1"}, {29'b0, st1}, {29'b0, SP_IDLE});
      check({tag, "_bits0"}, {27'b0, rd_bus0, slave_ready0, slave_valid0, split0, ram_wr_en0}, 32'd0);
      check({tag, "_bits1"}, {27'b0, rd_bus1, slave_ready1, slave_valid1, split1, ram_wr_en1}, 32'd0);
      check({tag, "_addr"}, {16'b0, addr0}, 32'd0);
      check({tag, "_ram_out"}, {24'b0, ram_out0}, 32'd0);
   endtask

   // ---------------- main sequence ----------------
   initial begin
      logic [AW-1:0] ra;
      logic [LW-1:0] rl;
      int n;
      for (int i = 0; i < 65536; i++) begin
         ram_mem[i] = 8'($urandom);
         ref_mem[i] = ram_mem[i];
      end
      rstn = 1'b0;
      repeat (3) tick();
      check_quiet("reset");
      rstn = 1'b1;
      tick();

      wbuf[0] = 8'hA5;
      do_write(16'h1234, 4'd0);
      check("single_write_idle", {29'b0, st0}, {29'b0, SP_IDLE});

      wbuf[0] = 8'h11; wbuf[1] = 8'h22; wbuf[2] = 8'h33;
      do_write(16'h0100, 4'd2);

      preload(16'h0040, 8'h3C);
      preload(16'h0041, 8'hC3);
      do_read(16'h0040, 4'd1, 1'b1);
      do_read(16'h0100, 4'd2, 1'b0);

      // Abort after 9 header bits.
      mode = 1'b1;
      master_valid = 1'b1;
      tick();
      for (int i = 0; i < 9; i++) send_bit(1'($urandom_range(0, 1)));
      master_valid = 1'b0;
      tick();
      tick();
      check("abort_hdr_idle", {29'b0, st0}, {29'b0, SP_IDLE});

      // Abort mid-WDATA.
      do_header(16'h2000, 4'd0, 1'b1);
      for (int i = 0; i < 3; i++) send_bit(1'b1);
      master_valid = 1'b0;
      tick();
      tick();
      check("abort_wdata_idle", {29'b0, st0}, {29'b0, SP_IDLE});

      wbuf[0] = 8'h5A;
      do_write(16'h2000, 4'd0);
      do_read(16'h2000, 4'd0, 1'b0);

      // Address wrap.
      wbuf[0] = 8'h77; wbuf[1] = 8'h88;
      do_write(16'hFFFF, 4'd1);
      do_read(16'hFFFF, 4'd1, 1'b0);

      // Full-length burst (2^LW words).
      ra = 16'($urandom);
      for (int i = 0; i < 16; i++) wbuf[i] = 8'($urandom);
      do_write(ra, 4'hF);
      do_read(ra, 4'hF, 1'b0);

      // Reset during SEND: nothing expected, everything quiet next cycle.
      do_header(16'h0040, 4'd1, 1'b0);
      master_valid = 1'b0;
      n = 0;
      while (!slave_valid0 && n < 20) begin
         tick();
         n++;
      end
      check("reach_send", {31'b0, slave_valid0}, 32'd1);
      master_ready = 1'b1;
      tick();
      tick();
      rstn = 1'b0;
      master_ready = 1'b0;
      tick();
      check_quiet("rst_send");
      rstn = 1'b1;
      tick();

      // Reset during WDATA: the partial word must never be written.
      do_header(16'h3000, 4'd0, 1'b1);
      for (int i = 0; i < 5; i++) send_bit(1'b1);
      rstn = 1'b0;
      master_valid = 1'b0;
      tick();
      check_quiet("rst_wdata");
      rstn = 1'b1;
      repeat (2) tick();

      // Randomized traffic.
      for (int t = 0; t < 25; t++) begin
         ra = 16'($urandom);
         rl = ($urandom_range(0, 7) == 0) ? 4'hF : 4'($urandom_range(0, 3));
         if ($urandom_range(0, 1) == 1) begin
            for (int i = 0; i < 16; i++) wbuf[i] = 8'($urandom);
            do_write(ra, rl);
         end else begin
            do_read(ra, rl, 1'b0);
         end
         repeat ($urandom_range(0, 3)) tick();
      end

      repeat (4) tick();
      check("wr_queue_empty", exp_wr_q.size(), 0);
      check("rd_queue_empty", exp_rd_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #900000;
      failures++;
      $display("FAIL watchdog actual=running expected=finished");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
